// File: rtl/pixel_color_sel.sv
// pixel_color_sel: two-stage registered colour selector with background substitution and highlight.
// Define PIXMUX_BLINK_EN to build the blink generator; without it a highlighted channel is always inverted.
module pixel_color_sel #(
   parameter int             W         = 12,
   parameter int             N         = 16,
   parameter int             SW        = 4,
   parameter logic [W-1:0]   BG        = 12'hFFF,
   parameter int             BLINK_DIV = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_in,
   input  logic [SW-1:0]    sel,
   input  logic [N*W-1:0]   din,
   input  logic             hl_en,
   input  logic [SW-1:0]    hl_sel,
   output logic [W-1:0]     dout,
   output logic             vld_out
);

   localparam int          NSEL  = 1 << SW;
   localparam logic [SW:0] N_LIM = (SW+1)'(N);

   if (NSEL < N || BLINK_DIV < 2) begin : g_bad_param
      $error("pixel_color_sel: need 2**SW >= N and BLINK_DIV >= 2");
   end

   // Full 2**SW entry table so any select indexes a defined entry.
   logic [W-1:0] chan [NSEL];

   for (genvar gi = 0; gi < NSEL; gi++) begin : g_chan
      if (gi < N) begin : g_din
         assign chan[gi] = din[gi*W +: W];
      end else begin : g_bg
         assign chan[gi] = BG;
      end
   end

   logic         in_range;
   logic         use_bg;
   logic [W-1:0] col_next;
   logic         hit_next;

   assign in_range = ({1'b0, sel} < N_LIM);
   assign use_bg   = (sel == '0) || !in_range;
   assign col_next = use_bg ? BG : chan[sel];
   assign hit_next = hl_en && (sel == hl_sel) && !use_bg;

   logic [W-1:0] col_reg;
   logic         hit_reg;
   logic         vld_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_reg <= BG;
         hit_reg <= 1'b0;
         vld_reg <= 1'b0;
      end else begin
         col_reg <= col_next;
         hit_reg <= hit_next;
         vld_reg <= vld_in;
      end
   end

   logic phase;

`ifdef PIXMUX_BLINK_EN
   localparam int           CW      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic          phase_reg;

   // Free-running; not gated by vld_in so the blink rate is independent of blanking.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else if (cnt_reg == CNT_MAX) begin
         cnt_reg   <= '0;
         phase_reg <= ~phase_reg;
      end else begin
         cnt_reg   <= cnt_reg + 1'b1;
      end
   end

   assign phase = phase_reg;
`else
   assign phase = 1'b1;
`endif

   logic [W-1:0] dout_next;

   always_comb begin
      dout_next = col_reg;
      if (!vld_reg) begin
         dout_next = BG;
      end else if (hit_reg && phase) begin
         dout_next = ~col_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout    <= BG;
         vld_out <= 1'b0;
      end else begin
         dout    <= dout_next;
         vld_out <= vld_reg;
      end
   end

endmodule
